hs32_bus_arb: RTL and testbench

HS32_BUS_ARB -- requirements
Module: hs32_bus_arb

---
 rtl/hs32_bus_arb_pkg.sv | 23 ++
 rtl/hs32_rr_arb2.sv | 27 ++
 rtl/hs32_bus_arb.sv | 142 ++++++++++++++
 tb/tb_hs32_bus_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_bus_arb_pkg.sv
// Shared types and defaults for the HS32 two-master bus arbiter.
// Holds the FSM state encoding, master id type and captured request record.
package hs32_bus_arb_pkg;

    localparam int unsigned HS32_TIMEOUT_DEFAULT = 255;
    localparam int unsigned HS32_TO_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // 0 = m0 (Wishbone), 1 = m1 (CPU)
    typedef logic mst_id_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dtw;
        logic        rw;
    } bus_req_t;

endpackage

// File: rtl/hs32_rr_arb2.sv
// Two-requester round-robin decision: applies lock and the post-ack mask,
// then breaks ties in favour of the master that was not granted last.
module hs32_rr_arb2
    import hs32_bus_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  logic    lock,
    input  logic    mask_vld,
    input  mst_id_t mask_id,
    input  mst_id_t last_grant,
    output logic    gnt_vld,
    output mst_id_t gnt_id
);

    logic elig0;
    logic elig1;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        elig0   = req0 && !(mask_vld && !mask_id);
        elig1   = req1 && !lock && !(mask_vld && mask_id);
        gnt_vld = elig0 || elig1;
        gnt_id  = (elig0 && elig1) ? !last_grant : elig1;
    end

endmodule

// File: rtl/hs32_bus_arb.sv
// HS32 bus arbiter: grants one of two masters, issues a single-cycle request
// to the interconnect and returns the slave ack, aborting after TIMEOUT waits.
module hs32_bus_arb
    import hs32_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = HS32_TIMEOUT_DEFAULT,
    parameter int unsigned TO_BITS = HS32_TO_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lock,
    input  logic        m0_stb,
    input  logic        m1_stb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_dtw,
    input  logic [31:0] m1_dtw,
    input  logic        m0_rw,
    input  logic        m1_rw,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m_dtr,
    output logic        m_err,
    output logic        s_stb,
    output logic [31:0] s_addr,
    output logic [31:0] s_dtw,
    output logic        s_rw,
    input  logic        s_ack,
    input  logic [31:0] s_dtr,
    output logic        s_abort,
    output logic        owner
);

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    arb_state_e         state;
    arb_state_e         next_state;
    bus_req_t           req_q;
    bus_req_t           win_req;
    mst_id_t            owner_q;
    mst_id_t            last_grant_q;
    mst_id_t            mask_id_q;
    logic               mask_vld_q;
    logic [TO_BITS-1:0] to_cnt_q;
    logic               gnt_vld;
    mst_id_t            gnt_id;
    logic               grant;
    logic               done;
    logic               expire;

    hs32_rr_arb2 u_rr_arb2 (
        .req0       (m0_stb),
        .req1       (m1_stb),
        .lock       (lock),
        .mask_vld   (mask_vld_q),
        .mask_id    (mask_id_q),
        .last_grant (last_grant_q),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        if (gnt_id) begin
            win_req.addr = m1_addr;
            win_req.dtw  = m1_dtw;
            win_req.rw   = m1_rw;
        end else begin
            win_req.addr = m0_addr;
            win_req.dtw  = m0_dtw;
            win_req.rw   = m0_rw;
        end
    end

    // NOTE: reset also gates the combinational outputs, so a transaction dropped by reset never acks in the reset cycle.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        s_stb      = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        grant      = 1'b1;
                        next_state = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    s_stb = 1'b1;
                    if (s_ack) done = 1'b1;
                    else       next_state = ST_WAIT;
                end
                ST_WAIT: begin
                    // A late s_ack on the expiry cycle still counts as a normal completion.
                    if (s_ack)                      done   = 1'b1;
                    else if (to_cnt_q == TO_LAST)   expire = 1'b1;
                end
                default: next_state = ST_IDLE;
            endcase
            if (done || expire) next_state = ST_IDLE;
        end
        m0_ack  = (done || expire) && !owner_q;
        m1_ack  = (done || expire) && owner_q;
        m_err   = expire;
        s_abort = expire;
        m_dtr   = done ? s_dtr : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mask_vld_q   <= 1'b0;
            mask_id_q    <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            mask_vld_q <= done || expire;
            mask_id_q  <= owner_q;
            if (grant) begin
                req_q        <= win_req;
                owner_q      <= gnt_id;
                last_grant_q <= gnt_id;
            end
            if (state == ST_ISSUE)              to_cnt_q <= '0;
            else if (state == ST_WAIT && !s_ack) to_cnt_q <= to_cnt_q + TO_BITS'(1);
        end
    end

    assign s_addr = req_q.addr;
    assign s_dtw  = req_q.dtw;
    assign s_rw   = req_q.rw;
    assign owner  = owner_q;

endmodule

// File: tb/tb_hs32_bus_arb.sv
// Self-checking bench for hs32_bus_arb: directed scenarios plus a randomized
// run scored against a transaction-age reference model.
module tb_hs32_bus_arb;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset, lock, m0_stb, m1_stb, m0_rw, m1_rw;
    logic [31:0] m0_addr, m1_addr, m0_dtw, m1_dtw;
    logic        m0_ack, m1_ack, m_err, s_stb, s_rw, s_ack, s_abort, owner;
    logic [31:0] m_dtr, s_addr, s_dtw, s_dtr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hs32_bus_arb #(.TIMEOUT(TO), .TO_BITS(8)) dut (
        .clk(clk), .reset(reset), .lock(lock),
        .m0_stb(m0_stb), .m1_stb(m1_stb),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dtw(m0_dtw), .m1_dtw(m1_dtw),
        .m0_rw(m0_rw), .m1_rw(m1_rw),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m_dtr(m_dtr), .m_err(m_err),
        .s_stb(s_stb), .s_addr(s_addr), .s_dtw(s_dtw), .s_rw(s_rw),
        .s_ack(s_ack), .s_dtr(s_dtr), .s_abort(s_abort), .owner(owner)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        lock = 0; m0_stb = 0; m1_stb = 0; m0_rw = 0; m1_rw = 0;
        m0_addr = '0; m1_addr = '0; m0_dtw = '0; m1_dtw = '0;
        s_ack = 0; s_dtr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; m0_stb = 1; m0_addr = 32'h44; s_ack = 1; s_dtr = 32'h9999_0001;
        tick();
        tick();
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, m_err, s_stb, s_abort, owner} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 000000", {m0_ack, m1_ack, m_err, s_stb, s_abort, owner});
        end
        n_checks++;
        if ({s_addr, s_dtw, s_rw, m_dtr} !== 97'b0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h dtw=%h rw=%b dtr=%h want all zero", s_addr, s_dtw, s_rw, m_dtr);
        end
        reset = 0; m0_stb = 0; s_ack = 0;
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, s_stb, s_abort} !== 4'b0) begin
            n_fail++; $display("FAIL reset_release: got %b want 0000", {m0_ack, m1_ack, s_stb, s_abort});
        end
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        m1_stb = 1; m1_addr = 32'h100; m1_rw = 0; m1_dtw = $urandom;
        settle();
        n_checks++;
        if (s_stb !== 1'b0) begin n_fail++; $display("FAIL single_idle_stb: got %b want 0", s_stb); end
        tick(); settle();
        n_checks++;
        if ({s_stb, s_addr, s_rw, owner} !== {1'b1, 32'h100, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL single_issue: got stb=%b addr=%h rw=%b owner=%b want 1 100 0 1", s_stb, s_addr, s_rw, owner);
        end
        tick(); settle();
        n_checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            n_fail++; $display("FAIL single_wait: got %b want 000", {s_stb, m0_ack, m1_ack});
        end
        tick();
        s_ack = 1; s_dtr = 32'hCAFE_F00D;
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, m_err, m_dtr} !== {3'b010, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL single_ack: got acks=%b err=%b dtr=%h want 01 0 cafef00d", {m0_ack, m1_ack}, m_err, m_dtr);
        end
        tick();
        m1_stb = 0; s_ack = 0;
        settle();
        n_checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            n_fail++; $display("FAIL single_after: got %b want 000", {s_stb, m0_ack, m1_ack});
        end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        m0_stb = 1; m0_addr = 32'hA0; m1_stb = 1; m1_addr = 32'hB0;
        settle();
        n_checks++;
        if (s_stb !== 1'b0) begin n_fail++; $display("FAIL tie_idle_stb: got %b want 0", s_stb); end
        tick();
        s_ack = 1; s_dtr = 32'hD0;
        settle();
        n_checks++;
        if ({s_stb, s_addr, owner, m0_ack, m1_ack} !== {1'b1, 32'hA0, 3'b010}) begin
            n_fail++; $display("FAIL tie_first: got stb=%b addr=%h owner=%b acks=%b want 1 a0 0 10", s_stb, s_addr, owner, {m0_ack, m1_ack});
        end
        tick();
        m0_stb = 0; s_ack = 0;
        settle();
        n_checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            n_fail++; $display("FAIL tie_gap: got %b want 000", {s_stb, m0_ack, m1_ack});
        end
        tick();
        s_ack = 1; s_dtr = 32'hD1;
        settle();
        n_checks++;
        if ({s_stb, s_addr, owner, m0_ack, m1_ack} !== {1'b1, 32'hB0, 3'b101}) begin
            n_fail++; $display("FAIL tie_second: got stb=%b addr=%h owner=%b acks=%b want 1 b0 1 01", s_stb, s_addr, owner, {m0_ack, m1_ack});
        end
        tick();
        m1_stb = 0; s_ack = 0;
        tick();
    endtask

    task automatic test_lock();
        int pulses;
        do_reset();
        lock = 1; m1_stb = 1; m1_addr = 32'h200;
        pulses = 0;
        repeat (6) begin
            settle();
            pulses += int'(s_stb);
            tick();
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL lock_hold: got %0d s_stb pulses want 0", pulses); end
        lock = 0;
        settle();
        n_checks++;
        if (s_stb !== 1'b0) begin n_fail++; $display("FAIL lock_drop_stb: got %b want 0", s_stb); end
        tick();
        lock = 1;
        settle();
        n_checks++;
        if ({s_stb, s_addr, owner} !== {1'b1, 32'h200, 1'b1}) begin
            n_fail++; $display("FAIL lock_grant: got stb=%b addr=%h owner=%b want 1 200 1", s_stb, s_addr, owner);
        end
        tick();
        s_ack = 1; s_dtr = 32'h1234;
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, m_err, s_abort, m_dtr} !== {4'b0100, 32'h1234}) begin
            n_fail++; $display("FAIL lock_midtxn: got acks=%b err=%b abort=%b dtr=%h want 01 0 0 1234", {m0_ack, m1_ack}, m_err, s_abort, m_dtr);
        end
        tick();
        m1_stb = 0; s_ack = 0; lock = 0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        m0_stb = 1; m0_addr = 32'h300; s_dtr = 32'h1234_5678;
        settle(); tick(); settle();
        n_checks++;
        if (s_stb !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b want 1", s_stb); end
        tick();
        for (int w = 1; w < int'(TO); w++) begin
            settle();
            n_checks++;
            if ({m0_ack, m1_ack, m_err, s_abort} !== 4'b0) begin
                n_fail++; $display("FAIL to_wait%0d: got %b want 0000", w, {m0_ack, m1_ack, m_err, s_abort});
            end
            tick();
        end
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, m_err, s_abort, m_dtr} !== {4'b1011, 32'h0}) begin
            n_fail++; $display("FAIL to_expire: got acks=%b err=%b abort=%b dtr=%h want 10 1 1 0", {m0_ack, m1_ack}, m_err, s_abort, m_dtr);
        end
        tick();
        m0_stb = 0; m1_stb = 1; m1_addr = 32'h310;
        settle();
        n_checks++;
        if ({s_stb, s_abort, m0_ack, m1_ack} !== 4'b0) begin
            n_fail++; $display("FAIL to_after: got %b want 0000", {s_stb, s_abort, m0_ack, m1_ack});
        end
        tick(); settle();
        n_checks++;
        if ({s_stb, s_addr} !== {1'b1, 32'h310}) begin
            n_fail++; $display("FAIL to_regrant: got stb=%b addr=%h want 1 310", s_stb, s_addr);
        end
        tick();
        repeat (TO - 1) tick();
        s_ack = 1; s_dtr = 32'hABCD;
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, m_err, s_abort, m_dtr} !== {4'b0100, 32'hABCD}) begin
            n_fail++; $display("FAIL to_ack_race: got acks=%b err=%b abort=%b dtr=%h want 01 0 0 abcd", {m0_ack, m1_ack}, m_err, s_abort, m_dtr);
        end
        tick();
        m1_stb = 0; s_ack = 0;
        tick();
    endtask

    task automatic test_zero_wait();
        do_reset();
        m0_stb = 1; m0_addr = 32'h400;
        settle(); tick();
        s_ack = 1; s_dtr = 32'h55;
        settle();
        n_checks++;
        if ({s_stb, m0_ack, m1_ack, m_dtr} !== {3'b110, 32'h55}) begin
            n_fail++; $display("FAIL zw_ack: got stb=%b acks=%b dtr=%h want 1 10 55", s_stb, {m0_ack, m1_ack}, m_dtr);
        end
        tick();
        s_ack = 0;
        settle();
        n_checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            n_fail++; $display("FAIL zw_stale: got %b want 000", {s_stb, m0_ack, m1_ack});
        end
        tick();
        m0_stb = 0;
        settle();
        n_checks++;
        if (s_stb !== 1'b0) begin n_fail++; $display("FAIL zw_no_regrant: got s_stb=%b want 0", s_stb); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        m1_stb = 1; m1_addr = 32'h500; m1_dtw = 32'hDEAD; m1_rw = 1;
        settle(); tick(); settle(); tick();
        reset = 1; s_ack = 1; s_dtr = 32'h77;
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, m_err, s_abort, s_stb, m_dtr} !== 37'b0) begin
            n_fail++; $display("FAIL rst_wait_cycle: got acks=%b err=%b abort=%b stb=%b dtr=%h want all 0", {m0_ack, m1_ack}, m_err, s_abort, s_stb, m_dtr);
        end
        tick();
        reset = 0; m1_stb = 0;
        settle();
        n_checks++;
        if ({m0_ack, m1_ack, m_err, s_abort, s_stb, owner, m_dtr} !== 38'b0) begin
            n_fail++; $display("FAIL rst_after_ctl: got acks=%b err=%b abort=%b stb=%b owner=%b dtr=%h want all 0", {m0_ack, m1_ack}, m_err, s_abort, s_stb, owner, m_dtr);
        end
        n_checks++;
        if ({s_addr, s_dtw, s_rw} !== 65'b0) begin
            n_fail++; $display("FAIL rst_after_data: got addr=%h dtw=%h rw=%b want 0", s_addr, s_dtw, s_rw);
        end
        tick();
        s_ack = 0;
        tick();
    endtask

    // Reference: a transaction is characterised only by its age since grant
    // (age 1 is the request cycle), its owner, and the captured request.
    task automatic test_random(input int n_cyc);
        bit          busy, own, last, mvld, mid, c_rw, e0, e1, win, done, tmo;
        int          age;
        logic [31:0] c_addr, c_dtw, exp_dtr;
        logic [4:0]  exp_ctl;
        bit          stb [2];
        bit          stale [2];
        bit          acked [2];
        bit          rw [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        do_reset();
        busy = 0; own = 0; last = 1; mvld = 0; mid = 0; age = 0;
        c_addr = '0; c_dtw = '0; c_rw = 0;
        for (int m = 0; m < 2; m++) begin
            stb[m] = 0; stale[m] = 0; acked[m] = 0; rw[m] = 0; a[m] = '0; d[m] = '0;
        end
        for (int c = 0; c < n_cyc; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (acked[m]) begin
                    if ($urandom_range(0, 1) == 1) stale[m] = 1;
                    else stb[m] = 0;
                end else if (stale[m]) begin
                    stb[m] = 0; stale[m] = 0;
                end else if (!stb[m] && $urandom_range(0, 2) == 0) begin
                    stb[m] = 1; a[m] = $urandom; d[m] = $urandom; rw[m] = 1'($urandom_range(0, 1));
                end
            end
            m0_stb = stb[0]; m0_addr = a[0]; m0_dtw = d[0]; m0_rw = rw[0];
            m1_stb = stb[1]; m1_addr = a[1]; m1_dtw = d[1]; m1_rw = rw[1];
            if ($urandom_range(0, 15) == 0) lock = !lock;
            s_ack = ($urandom_range(0, 3) == 0);
            s_dtr = $urandom;
            settle();

            exp_ctl = '0; exp_dtr = '0; done = 0; tmo = 0;
            if (busy) begin
                exp_ctl[4] = (age == 1);
                if (s_ack) done = 1;
                else if (age == int'(TO) + 1) tmo = 1;
                if (done || tmo) begin
                    exp_ctl[3:0] = {!own, own, tmo, tmo};
                    exp_dtr = done ? s_dtr : 32'h0;
                end
            end
            n_checks++;
            if ({s_stb, m0_ack, m1_ack, m_err, s_abort} !== exp_ctl) begin
                n_fail++; $display("FAIL rnd_ctl cyc %0d: got stb,ack0,ack1,err,abort=%b want %b", c, {s_stb, m0_ack, m1_ack, m_err, s_abort}, exp_ctl);
            end
            n_checks++;
            if (m_dtr !== exp_dtr) begin
                n_fail++; $display("FAIL rnd_dtr cyc %0d: got %h want %h", c, m_dtr, exp_dtr);
            end
            n_checks++;
            if (owner !== own) begin
                n_fail++; $display("FAIL rnd_owner cyc %0d: got %b want %b", c, owner, own);
            end
            n_checks++;
            if ({s_addr, s_dtw, s_rw} !== {c_addr, c_dtw, c_rw}) begin
                n_fail++; $display("FAIL rnd_req cyc %0d: got %h %h %b want %h %h %b", c, s_addr, s_dtw, s_rw, c_addr, c_dtw, c_rw);
            end

            acked[0] = exp_ctl[3];
            acked[1] = exp_ctl[2];
            if (busy) begin
                mvld = done || tmo;
                mid  = own;
                if (done || tmo) busy = 0;
                else age++;
            end else begin
                e0 = stb[0] && !(mvld && mid == 0);
                e1 = stb[1] && !lock && !(mvld && mid == 1);
                mvld = 0;
                if (e0 || e1) begin
                    win = (e0 && e1) ? !last : e1;
                    busy = 1; age = 1; own = win; last = win;
                    c_addr = a[win]; c_dtw = d[win]; c_rw = rw[win];
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_timeout();
        test_zero_wait();
        test_reset_mid_wait();
        test_random(1500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
